// File: rtl/adder_io_pkg.sv
// rtl/adder_io_pkg.sv - shared state encoding, operand width and default pad map for the IO adder
package adder_io_pkg;

   localparam int OPW              = 4;
   localparam int DEF_MPRJ_IO_PADS = 38;
   localparam int DEF_IN_LSB       = 7;
   localparam int DEF_OUT_LSB      = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ADD    = 2'd2,
      ST_DRIVE  = 2'd3
   } state_t;

endpackage

// File: rtl/io_sync_stable.sv
// rtl/io_sync_stable.sv - two-flop pad synchroniser with saturating stability counter
module io_sync_stable #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [WIDTH-1:0]                     d,
   output logic [WIDTH-1:0]                     s_op,
   output logic                                 stable,
   output logic [$clog2(STABLE_CYCLES+1)-1:0]   count
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] s_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_op   <= '0;
         s_prev <= '0;
         count  <= '0;
      end else begin
         sync_q <= d;
         s_op   <= sync_q;
         s_prev <= s_op;
         if (s_op != s_prev)
            count <= '0;
         else if (count != CW'(STABLE_CYCLES))
            count <= count + CW'(1);
      end
   end

   // A saturated count still describes s_prev on the cycle s_op moves, so gate it.
   assign stable = (count == CW'(STABLE_CYCLES)) && (s_op == s_prev);

endmodule

// File: rtl/io_adder_core.sv
// rtl/io_adder_core.sv - pad operand adder core; LA_DEBUG_EN enables registered logic-analyser taps
module io_adder_core
   import adder_io_pkg::*;
#(
   parameter int             MPRJ_IO_PADS  = DEF_MPRJ_IO_PADS,
   parameter int             IN_LSB        = DEF_IN_LSB,
   parameter int             OUT_LSB       = DEF_OUT_LSB,
   parameter logic [OPW-1:0] ADDEND        = 4'hA,
   parameter int             STABLE_CYCLES = 16
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [MPRJ_IO_PADS-1:0] io_in,
   output logic [MPRJ_IO_PADS-1:0] io_out,
   output logic [MPRJ_IO_PADS-1:0] io_oeb,
   output logic [31:0]             la_data_out
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [MPRJ_IO_PADS-1:0] OEB_RUN =
      ~({{(MPRJ_IO_PADS-OPW-1){1'b0}}, {(OPW+1){1'b1}}} << OUT_LSB);

   state_t         state;
   logic [OPW-1:0] s_op;
   logic           stable;
   logic [CW-1:0]  stable_count;
   logic [OPW-1:0] op_q;
   logic [OPW-1:0] committed;
   logic           committed_valid;
   logic [OPW:0]   result_q;
   logic           done_q;
   logic           unused_pads;

   assign unused_pads = ^io_in;

   io_sync_stable #(
      .WIDTH         (OPW),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_sync (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .d      (io_in[IN_LSB +: OPW]),
      .s_op   (s_op),
      .stable (stable),
      .count  (stable_count)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state           <= ST_IDLE;
         op_q            <= '0;
         committed       <= '0;
         committed_valid <= 1'b0;
         result_q        <= '0;
         done_q          <= 1'b0;
         io_out          <= '0;
         io_oeb          <= '1;
      end else begin
         io_oeb <= OEB_RUN;
         case (state)
            ST_IDLE: begin
               if (!committed_valid || s_op != committed)
                  state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (committed_valid && s_op == committed) begin
                  state <= ST_IDLE;
               end else if (stable) begin
                  // Freeze the operand here; s_op may move again before ADD.
                  op_q  <= s_op;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               result_q        <= {1'b0, op_q} + {1'b0, ADDEND};
               committed       <= op_q;
               committed_valid <= 1'b1;
               state           <= ST_DRIVE;
            end
            ST_DRIVE: begin
               io_out[OUT_LSB +: OPW+1] <= result_q;
               done_q                   <= ~done_q;
               state                    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LA_DEBUG_EN
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         la_data_out <= '0;
      else
         la_data_out <= {16'h0000, committed, done_q, 5'(stable_count), s_op, state};
   end
`else
   logic unused_dbg;
   assign unused_dbg  = ^{stable_count, done_q};
   assign la_data_out = '0;
`endif

endmodule

// File: tb/tb_io_adder_core.sv
// tb/tb_io_adder_core.sv - scoreboard bench for io_adder_core (default build and LA_DEBUG_EN)
module tb_io_adder_core;

   localparam int          SC       = 16;
   localparam logic [37:0] OEB_RUN  = 38'h3F_FFFF_07FF;
   localparam logic [37:0] OUT_MASK = 38'h00_0000_F800;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [37:0] io_in;
   logic [37:0] io_out;
   logic [37:0] io_oeb;
   logic [31:0] la_data_out;

   int          total  = 0;
   int          bad    = 0;
   int          events = 0;
   logic [4:0]  exp_q[$];
   logic        last_done = 1'b0;
   logic        done_obs;

   io_adder_core dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .io_in       (io_in),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .la_data_out (la_data_out)
   );

   always #5 wb_clk_i = ~wb_clk_i;

`ifdef LA_DEBUG_EN
   assign done_obs = la_data_out[11];
`else
   assign done_obs = dut.done_q;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every done toggle is one result, checked against the oldest expectation.
   always @(negedge wb_clk_i) begin
      if (wb_rst_i) begin
         last_done = 1'b0;
      end else if (done_obs !== last_done) begin
         last_done = done_obs;
         events++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", {59'd0, io_out[15:11]}, 64'hDEAD);
         end else begin
            check("result", {59'd0, io_out[15:11]}, {59'd0, exp_q.pop_front()});
            check("io_out_other_bits", io_out & ~OUT_MASK, 64'd0);
            check("io_oeb_run", io_oeb, OEB_RUN);
`ifndef LA_DEBUG_EN
            check("la_tied_zero", la_data_out, 64'd0);
`endif
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic set_op(input logic [3:0] v);
      io_in       = 38'h2A_AAAA_AAAA;
      io_in[10:7] = v;
   endtask

   task automatic wait_result(input string name, input int budget, output int lat);
      int start;
      start = events;
      lat   = 0;
      while (events == start && lat < budget) begin
         @(negedge wb_clk_i);
         #1;
         lat++;
      end
      check({name, "_arrived"}, 64'(events != start), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int ev0;
      set_op(4'b1011);
      wb_rst_i = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("reset_io_out", io_out, 64'd0);
      check("reset_io_oeb", io_oeb, 64'h3F_FFFF_FFFF);
      check("reset_la", la_data_out, 64'd0);

      // Test 1: 1011 + A -> carry 1, sum 0101
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      exp_q.push_back(5'b1_0101);
      cyc(1);
      @(negedge wb_clk_i);
      check("oeb_after_reset", io_oeb, OEB_RUN);
      #1;
      wait_result("t1", 40, lat);
      check("t1_latency_window", 64'(lat >= SC + 1 && lat <= SC + 8), 64'd1);
`ifdef LA_DEBUG_EN
      cyc(1);
      check("t1_la_committed", {60'd0, la_data_out[15:12]}, 64'hB);
      check("t1_la_done", {63'd0, la_data_out[11]}, 64'd1);
      check("t1_la_upper", {48'd0, la_data_out[31:16]}, 64'd0);
`endif

      // Test 3: re-presenting committed value does nothing
      ev0 = events;
      cyc(100);
      check("t3_no_new_result", 64'(events), 64'(ev0));
      check("t3_io_out_held", {59'd0, io_out[15:11]}, 64'h15);
      check("t3_la_quiet", {63'd0, la_data_out[11]},
`ifdef LA_DEBUG_EN
            64'd1);
`else
            64'd0);
`endif

      // Test 4: 0 + A, then 6 + A wraps with carry
      set_op(4'b0000);
      exp_q.push_back(5'b0_1010);
      wait_result("t4a", 40, lat);
      set_op(4'b0110);
      exp_q.push_back(5'b1_0000);
      wait_result("t4b", 40, lat);

      // Test 2: short glitch to 1011 must never be committed
      set_op(4'b1011);
      cyc(5);
      set_op(4'b0011);
      exp_q.push_back(5'b0_1101);
      wait_result("t2", 50, lat);
`ifdef LA_DEBUG_EN
      cyc(1);
      check("t2_la_committed", {60'd0, la_data_out[15:12]}, 64'h3);
`endif

      // Test 5: reset mid-SETTLE discards work, then the same value is recomputed
      set_op(4'b0101);
      cyc(8);
      wb_rst_i = 1'b1;
      cyc(1);
      @(negedge wb_clk_i);
      check("t5_reset_io_out", io_out, 64'd0);
      check("t5_reset_io_oeb", io_oeb, 64'h3F_FFFF_FFFF);
      check("t5_reset_la", la_data_out, 64'd0);
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      exp_q.push_back(5'b0_1111);
      wait_result("t5_after_reset", 40, lat);
      check("t5_latency_window", 64'(lat >= SC + 1 && lat <= SC + 8), 64'd1);

      // Reset with the committed value still presented: first result is still computed
      cyc(2);
      wb_rst_i = 1'b1;
      cyc(2);
      wb_rst_i = 1'b0;
      exp_q.push_back(5'b0_1111);
      wait_result("t5_same_value", 40, lat);

      cyc(4);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
